// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto a single-beat memory port, with
// per-owner read response routing and a watchdog for unanswered reads.
module mem_arbiter #(
  parameter int W       = 32,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_ren,
  input  logic          m1_ren,
  input  logic          m0_wen,
  input  logic          m1_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [W-1:0]  m0_wdata,
  input  logic [W-1:0]  m1_wdata,
  input  logic [3:0]    m0_wmask,
  input  logic [3:0]    m1_wmask,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic [W-1:0]  m0_rdata,
  output logic [W-1:0]  m1_rdata,
  output logic          m0_rd_valid,
  output logic          m1_rd_valid,
  output logic          m0_err,
  output logic          m1_err,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_rd_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state_r;
  logic          owner_r;
  logic          last_gnt_r;
  logic [7:0]    cnt_r;
  logic          req0_s;
  logic          req1_s;
  logic          win_valid_s;
  logic          win_s;
  logic          sel_write_s;
  logic [AW-1:0] sel_addr_s;
  logic [W-1:0]  sel_wdata_s;
  logic [3:0]    sel_wmask_s;
  logic          resp_data_s;
  logic          resp_timeout_s;

  assign req0_s         = m0_ren | m0_wen;
  assign req1_s         = m1_ren | m1_wen;
  assign resp_data_s    = (state_r == ST_WAIT) && mem_rd_valid;
  assign resp_timeout_s = (state_r == ST_WAIT) && !mem_rd_valid && (cnt_r == CNT_LAST);

  // Round-robin pick and field mux for the winning master
  always_comb begin
    win_valid_s = 1'b0;
    win_s       = 1'b0;
    if (req0_s && req1_s) begin
      win_valid_s = 1'b1;
      win_s       = ~last_gnt_r;
    end else if (req0_s) begin
      win_valid_s = 1'b1;
      win_s       = 1'b0;
    end else if (req1_s) begin
      win_valid_s = 1'b1;
      win_s       = 1'b1;
    end else begin
      win_valid_s = 1'b0;
      win_s       = 1'b0;
    end
    if (win_s) begin
      sel_write_s = m1_wen;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
      sel_wmask_s = m1_wmask;
    end else begin
      sel_write_s = m0_wen;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_wmask_s = m0_wmask;
    end
  end

  // Sequencer: arbitration, memory strobes (held only for the issue cycle) and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      owner_r    <= 1'b0;
      last_gnt_r <= 1'b1;
      cnt_r      <= 8'd0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= {AW{1'b0}};
      mem_wdata  <= {W{1'b0}};
      mem_wmask  <= 4'd0;
    end else begin
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s) begin
            state_r    <= ST_ISSUE;
            owner_r    <= win_s;
            last_gnt_r <= win_s;
            m0_gnt     <= ~win_s;
            m1_gnt     <= win_s;
            mem_wen    <= sel_write_s;
            mem_ren    <= ~sel_write_s;
            mem_addr   <= sel_addr_s;
            mem_wdata  <= sel_wdata_s;
            mem_wmask  <= sel_wmask_s;
          end
        end
        ST_ISSUE: begin
          state_r   <= mem_wen ? ST_IDLE : ST_WAIT;
          cnt_r     <= 8'd0;
          mem_ren   <= 1'b0;
          mem_wen   <= 1'b0;
          mem_addr  <= {AW{1'b0}};
          mem_wdata <= {W{1'b0}};
          mem_wmask <= 4'd0;
        end
        ST_WAIT: begin
          if (resp_data_s || resp_timeout_s) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_ren   <= 1'b0;
          mem_wen   <= 1'b0;
          mem_addr  <= {AW{1'b0}};
          mem_wdata <= {W{1'b0}};
          mem_wmask <= 4'd0;
        end
      endcase
    end
  end

  // Response routing; the non-owner's rdata is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= {W{1'b0}};
      m1_rdata    <= {W{1'b0}};
    end else begin
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      if (resp_data_s || resp_timeout_s) begin
        if (owner_r) begin
          m1_rd_valid <= 1'b1;
          m1_err      <= resp_timeout_s;
          m1_rdata    <= resp_data_s ? mem_rdata : {W{1'b0}};
        end else begin
          m0_rd_valid <= 1'b1;
          m0_err      <= resp_timeout_s;
          m0_rdata    <= resp_data_s ? mem_rdata : {W{1'b0}};
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master memory port arbiter placed between the memory and two bus masters: the cpu (master 0) and a second requester such as a DMA/loader (master 1). It serialises single-beat read and write requests onto the one memory port, using round-robin grant on contention. It routes each read response back to the master that issued it. A watchdog terminates reads the memory never answers.

## Interface
Parameters:
- W, 32, data width
- AW, 16, address width
- TIMEOUT, 15, cycles to wait for mem_rd_valid before aborting a read (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m0_ren, m1_ren  in  1  read request
- m0_wen, m1_wen  in  1  write request
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  W  write data
- m0_wmask, m1_wmask  in  4  byte write mask
- m0_gnt, m1_gnt  out  1  one-cycle pulse: request accepted
- m0_rdata, m1_rdata  out  W  read data
- m0_rd_valid, m1_rd_valid  out  1  one-cycle pulse: rdata valid
- m0_err, m1_err  out  1  pulses with rd_valid on timeout
- mem_ren, mem_wen  out  1  memory strobes
- mem_addr  out  AW
- mem_wdata  out  W
- mem_wmask  out  4
- mem_rdata  in  W
- mem_rd_valid  in  1

## Operation
- State machine: ST_IDLE, ST_ISSUE, ST_WAIT.
- A master requests when ren or wen is high. It must hold ren/wen/addr/wdata/wmask stable up to and including its gnt cycle.
- If a master has ren and wen high together, the request is a write and the read is ignored.
- ST_IDLE:
  - With no request, stay in ST_IDLE.
  - With exactly one requester, that master wins.
  - With both requesting, the master not granted last wins.
  - last_gnt resets to 1, so m0 wins the first tie.
  - On a win, latch owner, the op type and the request fields, update last_gnt, and go to ST_ISSUE.
- ST_ISSUE (exactly one cycle):
  - Drive the latched addr/wdata/wmask onto mem_*.
  - Assert mem_wen for a write or mem_ren for a read.
  - Pulse the owner's gnt.
  - A write then goes to ST_IDLE; a read goes to ST_WAIT and clears the timeout counter.
- ST_WAIT:
  - On mem_rd_valid, register mem_rdata into the owner's rdata, pulse the owner's rd_valid next cycle, and go to ST_IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT, pulse the owner's rd_valid and err with rdata=0, and go to ST_IDLE.
  - mem_rd_valid and the timeout in the same cycle: the data wins and err stays 0.
- mem_rd_valid outside ST_WAIT is ignored.
- The non-owner master's outputs never change during a transaction. mN_rdata holds its last value between responses.
- mem_ren and mem_wen are never high together. mem_* strobes are 0 outside ST_ISSUE, and mem_addr/wdata/wmask are 0 there too.
- Reset, asynchronous, all registers:
  - state=ST_IDLE, last_gnt=1, counter=0.
  - All gnt/rd_valid/err/mem_ren/mem_wen = 0; all rdata/mem_addr/mem_wdata = 0; mem_wmask = 0.
- Reset asserted mid-transaction aborts it: no rd_valid is produced, and any later mem_rd_valid is ignored.

## Timing
- Request seen high in ST_IDLE at edge N: ST_ISSUE occupies cycle N+1, with gnt and mem strobe high during it.
- Write: 2 cycles from request to acceptance. The next request can be sampled at edge N+2.
- Read, with memory answering mem_rd_valid one cycle after mem_ren (cycle N+2):
  - owner rd_valid is high in cycle N+3;
  - the arbiter is back in ST_IDLE in cycle N+3 and can accept a new request on the N+3 edge.
- Timeout: rd_valid/err rise TIMEOUT+1 cycles after the ST_ISSUE cycle.
- Back-to-back contention alternates strictly m0, m1, m0, … A continuously requesting master never starves the other.
- The arbiter adds no combinational path from any mN_* input to any mem_* output. All outputs are registered or decoded from state only.

## Test plan
- Reset: hold rst_n=0 with both masters requesting → all outputs 0. Release rst_n → m0 gnt first, in the second cycle after release.
- Single write from m1 (addr=0x0040, wdata=0xDEADBEEF, wmask=1111):
  - mem_wen is high for one cycle with those values, together with m1_gnt;
  - m0 outputs stay 0.
- Contended reads: m0 (addr 0x0010) and m1 (addr 0x0020) both request continuously, memory replies 1 cycle later with addr-derived data →
  - grants alternate m0, m1, m0, m1;
  - each rd_valid carries only its own address's data;
  - each read completes in 3 cycles.
- Read timeout: m0 reads, memory never asserts mem_rd_valid → m0_rd_valid=m0_err=1 with m0_rdata=0, exactly 16 cycles after ISSUE (TIMEOUT=15). A late mem_rd_valid afterwards is ignored.
- Simultaneous ren+wen from m0 → treated as a write: mem_wen=1, mem_ren=0, and no rd_valid follows.
- rst_n pulsed low during ST_WAIT → no rd_valid or err appears, state returns to ST_IDLE, and m0 wins the next tie.
